dual_frame_comparator: RTL
==========================

// Module: dual_frame_comparator
// PURPOSE
//  Upstream stage of the output controller. Receives the same data stream from two redundant
//  modules (A, B), buffers each in a small FIFO and compares the streams word by word.
//  Each time a frame finishes it issues one verdict: modStatus1/2, the outputEn1/2 release
//  and a single-cycle dataReady pulse. The output controller gates its outputs and its
//  100 ms liveness timer on these signals.
// PARAMETERS
//  DATA_W    16    width of one bus word
//  DEPTH     8     per-channel FIFO depth in words; power of 2, >=2
//  SKEW_MAX  1000  max cycles one channel may hold data while the other is empty
// PORTS
//  clk1        in   1       comparison base clock, all logic on posedge
//  rst         in   1       async, active-high reset
//  aValid      in   1       channel A word strobe
//  aData       in   DATA_W  channel A word
//  aLast       in   1       channel A last word of frame
//  aReady      out  1       channel A FIFO not full
//  bValid/bData/bLast/bReady   same as A, for channel B
//  outputEn1   out  1       A-side output enable, active low (0 = verdict valid)
//  outputEn2   out  1       B-side output enable, active low
//  modStatus1  out  8       A-side verdict register
//  modStatus2  out  8       B-side verdict register
//  dataReady   out  1       1-cycle pulse per verdict; its falling edge marks new data
// BEHAVIOUR
//  Reset (async): FIFOs empty; state IDLE; aReady=bReady=1; outputEn1=outputEn2=1;
//   modStatus1=modStatus2=0; dataReady=0; seq=0; skew counter 0; drop flags 0.
//  Writes: a word is written when xValid && xReady. xReady = !full.
//   xValid while full sets the sticky ovf_x flag for the current frame; the word is lost.
//  modStatus bits, A-side view. B-side is mirrored: bits [0]/[1] swapped, [5] from ovf_b.
//   [0] own frame complete  [1] peer frame complete  [2] FAIL = [3]|[4]|[5]
//   [3] skew timeout        [4] data/length mismatch [5] own overflow  [7:6] seq
//  FSM:
//   IDLE    -> COMPARE when either FIFO is non-empty. outputEn1/2 <= 1 on this transition.
//   COMPARE -> pops both FIFOs in the same cycle when both are non-empty.
//              - aData!=bData sets mis.
//              - Frame ends when either popped word has last set.
//              - If aLast!=bLast: set mis, and set drop_x for the side that did not end.
//   COMPARE -> VERDICT at frame end.
//   COMPARE -> VERDICT on timeout: skew counter reaches SKEW_MAX; sets skew; flushes both FIFOs.
//   VERDICT -> IDLE, one cycle. Register modStatus1/2; outputEn1/2 <= 0; dataReady <= 1;
//              seq <= seq+1, wrapping 3 -> 0; clear mis/skew/ovf. dataReady returns to 0 next cycle.
//  Skew counter: increments in COMPARE when exactly one FIFO is non-empty.
//   Clears when both FIFOs are non-empty or both empty. Saturates at SKEW_MAX.
//  drop_x: words written on side x are discarded, not stored, up to and including the next
//   xLast. drop_x then clears. Discarded words do not set ovf.
//  Latency: final pair popped in cycle N -> at N+1 status valid, outputEn=0, dataReady=1;
//   dataReady=0 at N+2.
//  outputEn1/2 stay 0, holding the last verdict, until the next frame's first word moves IDLE->COMPARE.
//  Simultaneous write+pop on the same FIFO is legal, including when full (ready is from registered full).
//  rst mid-frame: all state and outputs return to reset values immediately; partial frame discarded.
// TESTING
//  1 Identical 4-word frames 0x1111..0x4444 on A and B
//    -> one dataReady pulse; modStatus1=modStatus2=8'h43; outputEn1=outputEn2=0.
//  2 Same frames, but B word 3 = 0x3334
//    -> modStatus1=modStatus2=8'h57 ([4],[2] set); frame still fully drained.
//  3 SKEW_MAX=16; A sends 4 words, B silent
//    -> verdict 17 cycles after A's first word; modStatus1=8'h4D, modStatus2=8'h4E; FIFOs empty.
//  4 A frame is 3 words, B frame is 4 words, then an identical frame on both
//    -> first verdict has [4] set, B word 4 dropped; second verdict 8'h83, clean.
//  5 DEPTH=8; A valid for 10 consecutive cycles, B idle
//    -> aReady low after 8 words; verdict modStatus1[5]=1 and [2]=1.
//  6 rst pulsed during word 2 of a frame
//    -> outputEn1/2=1, modStatus=0, dataReady=0, readies=1; the next full frame gives seq=1.

Source files
------------

// File: rtl/dual_frame_comparator.sv
// dual_frame_comparator: buffers two redundant word streams and issues one compare verdict per frame
module dual_frame_comparator #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int SKEW_MAX = 1000
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              aValid,
  input  logic [DATA_W-1:0] aData,
  input  logic              aLast,
  output logic              aReady,
  input  logic              bValid,
  input  logic [DATA_W-1:0] bData,
  input  logic              bLast,
  output logic              bReady,
  output logic              outputEn1,
  output logic              outputEn2,
  output logic [7:0]        modStatus1,
  output logic [7:0]        modStatus2,
  output logic              dataReady
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SKEW_MAX + 1);
  typedef enum logic [1:0] {IDLE, COMPARE, VERDICT} state_t;
  state_t          r_state;
  logic [DATA_W:0] r_mem_a [DEPTH];
  logic [DATA_W:0] r_mem_b [DEPTH];
  logic [AW:0]     r_wp_a, r_rp_a, r_wp_b, r_rp_b;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_seq;
  logic            r_mis, r_ovf_a, r_ovf_b, r_cmp_a, r_cmp_b, r_drop_a, r_drop_b;
  logic            w_ne_a, w_ne_b, w_pop, w_end, w_to, w_vd, w_fl_a, w_fl_b;
  logic            w_in_a, w_in_b, w_wr_a, w_wr_b, w_mis, w_oa, w_ob, w_ca, w_cb, w_start;
  logic [DATA_W:0] w_ha, w_hb;
  logic [1:0]      w_seq;
  assign aReady  = (r_wp_a - r_rp_a) != (AW+1)'(DEPTH);
  assign bReady  = (r_wp_b - r_rp_b) != (AW+1)'(DEPTH);
  assign w_ne_a  = r_wp_a != r_rp_a;
  assign w_ne_b  = r_wp_b != r_rp_b;
  assign w_ha    = r_mem_a[r_rp_a[AW-1:0]];
  assign w_hb    = r_mem_b[r_rp_b[AW-1:0]];
  assign w_start = r_state == IDLE && (w_ne_a || w_ne_b);
  assign w_pop   = r_state == COMPARE && w_ne_a && w_ne_b;
  assign w_end   = w_pop && (w_ha[DATA_W] || w_hb[DATA_W]);
  assign w_to    = r_state == COMPARE && (w_ne_a ^ w_ne_b) && r_cnt == CW'(SKEW_MAX - 1);
  assign w_vd    = w_end || w_to;
  // the side whose frame did not end loses whatever of that frame is still buffered
  assign w_fl_a  = w_to || (w_end && !w_ha[DATA_W]);
  assign w_fl_b  = w_to || (w_end && !w_hb[DATA_W]);
  assign w_in_a  = aValid && aReady && !r_drop_a;
  assign w_in_b  = bValid && bReady && !r_drop_b;
  assign w_wr_a  = w_in_a && !w_fl_a;
  assign w_wr_b  = w_in_b && !w_fl_b;
  assign w_oa    = r_ovf_a || (aValid && !aReady && !r_drop_a);
  assign w_ob    = r_ovf_b || (bValid && !bReady && !r_drop_b);
  assign w_ca    = r_cmp_a || (w_in_a && aLast);
  assign w_cb    = r_cmp_b || (w_in_b && bLast);
  assign w_mis   = r_mis || (w_pop && w_ha != w_hb);
  assign w_seq   = r_seq + 2'd1;
  always_ff @(posedge clk1) begin
    if (w_wr_a) r_mem_a[r_wp_a[AW-1:0]] <= {aLast, aData};
    if (w_wr_b) r_mem_b[r_wp_b[AW-1:0]] <= {bLast, bData};
  end
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wp_a     <= '0;
      r_rp_a     <= '0;
      r_wp_b     <= '0;
      r_rp_b     <= '0;
      r_cnt      <= '0;
      r_seq      <= '0;
      r_mis      <= 1'b0;
      r_ovf_a    <= 1'b0;
      r_ovf_b    <= 1'b0;
      r_cmp_a    <= 1'b0;
      r_cmp_b    <= 1'b0;
      r_drop_a   <= 1'b0;
      r_drop_b   <= 1'b0;
      outputEn1  <= 1'b1;
      outputEn2  <= 1'b1;
      modStatus1 <= '0;
      modStatus2 <= '0;
      dataReady  <= 1'b0;
    end else begin
      r_wp_a    <= r_wp_a + (AW+1)'(w_wr_a);
      r_wp_b    <= r_wp_b + (AW+1)'(w_wr_b);
      r_rp_a    <= w_fl_a ? r_wp_a : r_rp_a + (AW+1)'(w_pop);
      r_rp_b    <= w_fl_b ? r_wp_b : r_rp_b + (AW+1)'(w_pop);
      r_drop_a  <= (w_end && !w_ha[DATA_W]) ? !w_ca : r_drop_a && !(aValid && aReady && aLast);
      r_drop_b  <= (w_end && !w_hb[DATA_W]) ? !w_cb : r_drop_b && !(bValid && bReady && bLast);
      r_mis     <= !w_vd && w_mis;
      r_ovf_a   <= !w_vd && w_oa;
      r_ovf_b   <= !w_vd && w_ob;
      r_cmp_a   <= !w_vd && w_ca;
      r_cmp_b   <= !w_vd && w_cb;
      r_cnt     <= (r_state == COMPARE && !w_vd && (w_ne_a ^ w_ne_b)) ? r_cnt + 1'b1 : '0;
      dataReady <= w_vd;
      r_state   <= w_vd ? VERDICT : r_state == VERDICT ? IDLE : w_start ? COMPARE : r_state;
      if (w_vd) begin
        modStatus1 <= {w_seq, w_oa, w_mis, w_to, w_to || w_mis || w_oa, w_cb, w_ca};
        modStatus2 <= {w_seq, w_ob, w_mis, w_to, w_to || w_mis || w_ob, w_ca, w_cb};
        outputEn1  <= 1'b0;
        outputEn2  <= 1'b0;
        r_seq      <= w_seq;
      end else if (w_start) begin
        outputEn1 <= 1'b1;
        outputEn2 <= 1'b1;
      end
    end
  end
endmodule
